// File: rtl/uart_tx_param.sv
// Single-clock UART transmitter with integrated TX FIFO, runtime baud divisor and 1/2 stop bits.
// Define UART_TX_PARITY_EN to build odd/even parity generation; otherwise par_mode is ignored.
module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [1:0]                    par_mode,
    input  logic                          stop2,
    input  logic                          tx_fifo_wen,
    input  logic [DATA_W-1:0]             tx_fifo_wdata,
    output logic                          tx_fifo_full,
    output logic                          tx_fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_usedw,
    output logic                          tx_fifo_ovf,
    output logic                          txd,
    output logic                          tx_work
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int BW    = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t              r_state, w_state_next;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr, r_rptr;
    logic [CNT_W-1:0]    r_count, w_count_next;
    logic                r_full, r_empty, r_ovf;
    logic                w_push, w_pop, w_start, w_can_start, w_bit_end, w_par_on;
    logic [DATA_W-1:0]   r_data, w_data_next, w_head;
    logic [DIV_W-1:0]    r_div, w_div_next, r_cnt, w_cnt_next;
    logic [1:0]          r_par, w_par_next, w_par_sel;
    logic                r_stop2, w_stop2_next, r_stop_idx, w_stop_idx_next;
    logic [BW-1:0]       r_bit, w_bit_next;
    logic                r_txd, w_txd_next, r_work;

`ifdef UART_TX_PARITY_EN
    function automatic logic f_parity(input logic [DATA_W-1:0] d, input logic [1:0] mode);
        f_parity = (mode == 2'b10) ? (^d) : (~^d);
    endfunction

    assign w_par_sel = par_mode;
    assign w_par_on  = (r_par == 2'b01) || (r_par == 2'b10);
`else
    logic w_unused_par;
    assign w_par_sel    = 2'b00;
    assign w_par_on     = 1'b0;
    assign w_unused_par = ^{par_mode, r_par};
`endif

    assign w_head      = r_mem[r_rptr];
    assign w_can_start = ena && !r_empty;
    assign w_bit_end   = (r_cnt == DIV_W'(0));
    // A pop frees a slot in the same cycle, so a write while full is accepted then.
    assign w_push      = tx_fifo_wen && (!r_full || w_pop);

    // FIFO occupancy next value
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage; no reset needed because reads are gated by the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_fifo_wdata;
        end
    end

    // FIFO pointers, count and registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= AW'(0);
            r_rptr  <= AW'(0);
            r_count <= CNT_W'(0);
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
            r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(FIFO_DEPTH));
            r_empty <= (w_count_next == CNT_W'(0));
            r_ovf   <= tx_fifo_wen && r_full && !w_pop;
        end
    end

    // Frame sequencing; txd is computed from the next state so the line is registered
    always_comb begin
        w_state_next    = r_state;
        w_start         = 1'b0;
        w_pop           = 1'b0;
        w_data_next     = r_data;
        w_div_next      = r_div;
        w_par_next      = r_par;
        w_stop2_next    = r_stop2;
        w_bit_next      = r_bit;
        w_stop_idx_next = r_stop_idx;
        w_cnt_next      = (r_state == S_IDLE) ? r_cnt : r_cnt - DIV_W'(1);
        w_txd_next      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_can_start) w_start = 1'b1;
                else             w_state_next = S_IDLE;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_bit_next   = BW'(0);
                    w_cnt_next   = r_div;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next = r_div;
                    if (r_bit == BW'(DATA_W - 1)) begin
                        w_state_next    = w_par_on ? S_PARITY : S_STOP;
                        w_stop_idx_next = 1'b0;
                    end else begin
                        w_bit_next = r_bit + BW'(1);
                    end
                end else begin
                    w_state_next = S_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next    = S_STOP;
                    w_stop_idx_next = 1'b0;
                    w_cnt_next      = r_div;
                end else begin
                    w_state_next = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (!w_bit_end) begin
                    w_state_next = S_STOP;
                end else if (r_stop2 && !r_stop_idx) begin
                    w_stop_idx_next = 1'b1;
                    w_cnt_next      = r_div;
                end else if (w_can_start) begin
                    w_start = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Word and line settings are captured together so mid-frame changes cannot tear a frame.
        if (w_start) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
            w_data_next  = w_head;
            w_div_next   = baud_div;
            w_cnt_next   = baud_div;
            w_par_next   = w_par_sel;
            w_stop2_next = stop2;
        end else begin
            w_pop = 1'b0;
        end

        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_data_next[w_bit_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_next = f_parity(r_data, r_par);
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    // Transmitter state and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_data     <= DATA_W'(0);
            r_div      <= DIV_W'(0);
            r_cnt      <= DIV_W'(0);
            r_par      <= 2'b00;
            r_stop2    <= 1'b0;
            r_bit      <= BW'(0);
            r_stop_idx <= 1'b0;
            r_txd      <= 1'b1;
            r_work     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_data     <= w_data_next;
            r_div      <= w_div_next;
            r_cnt      <= w_cnt_next;
            r_par      <= w_par_next;
            r_stop2    <= w_stop2_next;
            r_bit      <= w_bit_next;
            r_stop_idx <= w_stop_idx_next;
            r_txd      <= w_txd_next;
            r_work     <= (w_state_next != S_IDLE);
        end
    end

    assign tx_fifo_full  = r_full;
    assign tx_fifo_empty = r_empty;
    assign tx_fifo_usedw = r_count;
    assign tx_fifo_ovf   = r_ovf;
    assign txd           = r_txd;
    assign tx_work       = r_work;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (DATA_W=8, FIFO_DEPTH=16, DIV_W=16).
// Parity expectations follow UART_TX_PARITY_EN in the same way the design does.
module tb_uart_tx_param;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic [DIV_W-1:0]  baud_div;
    logic [1:0]        par_mode;
    logic              stop2;
    logic              tx_fifo_wen;
    logic [DATA_W-1:0] tx_fifo_wdata;
    logic              tx_fifo_full;
    logic              tx_fifo_empty;
    logic [4:0]        tx_fifo_usedw;
    logic              tx_fifo_ovf;
    logic              txd;
    logic              tx_work;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .ena(ena), .baud_div(baud_div), .par_mode(par_mode),
        .stop2(stop2), .tx_fifo_wen(tx_fifo_wen), .tx_fifo_wdata(tx_fifo_wdata),
        .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
        .tx_fifo_usedw(tx_fifo_usedw), .tx_fifo_ovf(tx_fifo_ovf),
        .txd(txd), .tx_work(tx_work)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        tx_fifo_wen   = 1'b1;
        tx_fifo_wdata = d;
        tick();
        tx_fifo_wen   = 1'b0;
    endtask

    // Called on the first cycle of the start bit; returns on the cycle after the last stop cycle.
    task automatic expect_frame(input logic [7:0] d, input int div, input logic [1:0] pm, input logic s2);
        logic [15:0] bits;
        int n;
        bits    = 16'hFFFF;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (PAR_EN && (pm == 2'b01 || pm == 2'b10)) begin
            bits[n] = (pm == 2'b10) ? (^d) : ~(^d);
            n++;
        end
        n = n + (s2 ? 2 : 1);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c <= div; c++) begin
                check("frame", {tx_work, txd}, {1'b1, bits[b]});
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; baud_div = 16'd3; par_mode = 2'b00; stop2 = 1'b0;
        tx_fifo_wen = 1'b0; tx_fifo_wdata = 8'h00;
        repeat (3) tick();
        check("rst_txd", txd, 1'b1);
        check("rst_work", tx_work, 1'b0);
        check("rst_full", tx_fifo_full, 1'b0);
        check("rst_empty", tx_fifo_empty, 1'b1);
        check("rst_usedw", tx_fifo_usedw, 5'd0);
        check("rst_ovf", tx_fifo_ovf, 1'b0);
        rst = 1'b0;
        ena = 1'b1;
        tick();

        // Basic 8N1 frame: start two cycles after the write, 40 cycles long.
        push_word(8'h55);
        check("wr_empty", tx_fifo_empty, 1'b0);
        check("wr_usedw", tx_fifo_usedw, 5'd1);
        tick();
        expect_frame(8'h55, 3, 2'b00, 1'b0);
        check("idle_55", {tx_work, txd}, 2'b01);

        // Both parity modes on 0x07 (44 cycles with parity, 40 when compiled out).
        for (int m = 1; m <= 2; m++) begin
            par_mode = 2'(m);
            push_word(8'h07);
            tick();
            expect_frame(8'h07, 3, 2'(m), 1'b0);
            check("idle_par", {tx_work, txd}, 2'b01);
        end
        par_mode = 2'b00;

        // Overflow: 17 writes with transmit disabled, then drain.
        ena = 1'b0;
        baud_div = 16'd1;
        for (int i = 0; i < 17; i++) begin
            tx_fifo_wen   = 1'b1;
            tx_fifo_wdata = 8'h10 + 8'(i);
            tick();
            check("ovf_pulse", tx_fifo_ovf, (i == 16) ? 1'b1 : 1'b0);
        end
        tx_fifo_wen = 1'b0;
        check("full_usedw", tx_fifo_usedw, 5'd16);
        check("full_flag", tx_fifo_full, 1'b1);
        tick();
        check("ovf_clear", tx_fifo_ovf, 1'b0);
        check("no_start_dis", {tx_work, txd}, 2'b01);
        ena = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            expect_frame(8'h10 + 8'(i), 1, 2'b00, 1'b0);
        end
        check("drain_idle", {tx_work, txd}, 2'b01);
        check("drain_empty", tx_fifo_empty, 1'b1);

        // Two stop bits, back-to-back frames with no idle gap.
        baud_div = 16'd3;
        stop2 = 1'b1;
        tx_fifo_wen = 1'b1;
        tx_fifo_wdata = 8'hA5;
        tick();
        tx_fifo_wdata = 8'h3C;
        tick();
        tx_fifo_wen = 1'b0;
        expect_frame(8'hA5, 3, 2'b00, 1'b1);
        expect_frame(8'h3C, 3, 2'b00, 1'b1);
        check("idle_b2b", {tx_work, txd}, 2'b01);
        stop2 = 1'b0;

        // Divisor change mid-frame only affects the next frame.
        push_word(8'h96);
        push_word(8'h0F);
        baud_div = 16'd7;
        expect_frame(8'h96, 3, 2'b00, 1'b0);
        expect_frame(8'h0F, 7, 2'b00, 1'b0);
        check("idle_div", {tx_work, txd}, 2'b01);
        baud_div = 16'd3;

        // Enable dropped mid-frame: frame completes, queued word stays.
        push_word(8'h81);
        push_word(8'h42);
        ena = 1'b0;
        expect_frame(8'h81, 3, 2'b00, 1'b0);
        check("ena_stop", {tx_work, txd}, 2'b01);
        repeat (10) tick();
        check("ena_hold", {tx_work, txd}, 2'b01);
        check("ena_usedw", tx_fifo_usedw, 5'd1);

        // Reset during data bit 3 discards the frame and the queue.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("clr_usedw", tx_fifo_usedw, 5'd0);
        push_word(8'hA5);
        push_word(8'h11);
        push_word(8'h22);
        check("q3_usedw", tx_fifo_usedw, 5'd3);
        ena = 1'b1;
        tick();
        repeat (16) tick();
        check("bit3", {tx_work, txd}, 2'b10);
        rst = 1'b1;
        tick();
        check("mrst_txd", txd, 1'b1);
        check("mrst_work", tx_work, 1'b0);
        check("mrst_empty", tx_fifo_empty, 1'b1);
        check("mrst_usedw", tx_fifo_usedw, 5'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("post_rst", {tx_work, txd}, 2'b01);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
